// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared types and bus helpers for the motion-estimation best-MV tracker
package me_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam int BUS_MAX = 512;

  function automatic logic [31:0] sad_max(input int w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

  // Generic lane extractor for packed sad/col/row buses; caller truncates to its width.
  function automatic logic [31:0] bus_slice(input logic [BUS_MAX-1:0] bus, input int idx, input int w);
    return 32'(bus >> (idx * w)) & sad_max(w);
  endfunction

endpackage

// File: rtl/sad_min_lane.sv
// rtl/sad_min_lane.sv - running-minimum SAD register with position capture for one partition
module sad_min_lane
  import me_pkg::*;
#(
  parameter int SAD_W = 16,
  parameter int COL_W = 5,
  parameter int ROW_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             upd,
  input  logic [SAD_W-1:0] sad,
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] row,
  input  logic [SAD_W-1:0] thr,
  output logic [SAD_W-1:0] best_sad,
  output logic [COL_W-1:0] best_col,
  output logic [ROW_W-1:0] best_row,
  output logic             le_thr
);

  localparam logic [SAD_W-1:0] SAD_MAX_V = SAD_W'(sad_max(SAD_W));

  logic [SAD_W-1:0] sad_q, sad_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Strict less-than so that ties keep the earliest position in scan order.
  always_comb begin
    sad_d = sad_q;
    col_d = col_q;
    row_d = row_q;
    if (init) begin
      sad_d = SAD_MAX_V;
      col_d = '0;
      row_d = '0;
    end else if (upd && (sad < sad_q)) begin
      sad_d = sad;
      col_d = col;
      row_d = row;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sad_q <= SAD_MAX_V;
      col_q <= '0;
      row_q <= '0;
    end else begin
      sad_q <= sad_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Judged on the post-update minimum so the terminating sample counts.
  assign le_thr   = (sad_d <= thr);
  assign best_sad = sad_q;
  assign best_col = col_q;
  assign best_row = row_q;

endmodule

// File: rtl/sad_best_mv_tracker.sv
// rtl/sad_best_mv_tracker.sv - per-partition best motion vector tracker with early termination
module sad_best_mv_tracker
  import me_pkg::*;
#(
  parameter int NUM_PART = 4,
  parameter int SAD_W    = 16,
  parameter int COL_W    = 5,
  parameter int ROW_W    = 7,
  parameter int CNT_W    = 12,
  parameter int EARLY_EN = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sad_valid,
  input  logic [NUM_PART*SAD_W-1:0] sad_bus,
  input  logic [COL_W-1:0]          search_col,
  input  logic [ROW_W-1:0]          search_row,
  input  logic                      last_pos,
  input  logic [SAD_W-1:0]          early_thr,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      result_valid,
  output logic                      early_term,
  output logic [NUM_PART*SAD_W-1:0] best_sad,
  output logic [NUM_PART*COL_W-1:0] best_col,
  output logic [NUM_PART*ROW_W-1:0] best_row,
  output logic [CNT_W-1:0]          pos_count
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               early_q, early_d;
  logic               init, upd;
  logic [NUM_PART-1:0] le_thr;
  logic               early_hit;

  for (genvar p = 0; p < NUM_PART; p++) begin : g_lane
    sad_min_lane #(
      .SAD_W (SAD_W),
      .COL_W (COL_W),
      .ROW_W (ROW_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .init     (init),
      .upd      (upd),
      .sad      (SAD_W'(bus_slice(BUS_MAX'(sad_bus), p, SAD_W))),
      .col      (search_col),
      .row      (search_row),
      .thr      (early_thr),
      .best_sad (best_sad[p*SAD_W +: SAD_W]),
      .best_col (best_col[p*COL_W +: COL_W]),
      .best_row (best_row[p*ROW_W +: ROW_W]),
      .le_thr   (le_thr[p])
    );
  end

  assign early_hit = (EARLY_EN != 0) && (&le_thr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    early_d = early_q;
    init    = 1'b0;
    upd     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          init    = 1'b1;
          cnt_d   = '0;
          early_d = 1'b0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        // A restart wins over a coincident sample, which is dropped.
        if (start) begin
          init    = 1'b1;
          cnt_d   = '0;
          early_d = 1'b0;
        end else if (sad_valid) begin
          upd   = 1'b1;
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          if (early_hit) begin
            early_d = 1'b1;
            state_d = HOLD;
          end else if (last_pos) begin
            early_d = 1'b0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (start) begin
            init    = 1'b1;
            cnt_d   = '0;
            early_d = 1'b0;
            state_d = SEARCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      early_q <= early_d;
    end
  end

  assign busy         = (state_q == SEARCH);
  assign result_valid = (state_q == HOLD);
  assign early_term   = early_q;
  assign pos_count    = cnt_q;

endmodule

// File: doc/sad_best_mv_tracker.md
Name: sad_best_mv_tracker

Overview:
- Per-partition best-motion-vector tracker that sits after the basic layer search SAD array.
- Each search position, the SAD array delivers NUM_PART packed SADs with the current search column/row.
- This block keeps the running minimum SAD and its (col,row) per partition.
- It supports optional early termination on a threshold and presents the results under a valid/ready handshake to the mode-decision stage.

Parameters:
- NUM_PART, 4, number of partitions tracked in parallel.
- SAD_W, 16, unsigned SAD width per partition.
- COL_W, 5, search column index width.
- ROW_W, 7, search row index width.
- CNT_W, 12, width of the accepted-position counter.
- EARLY_EN, 1, enables threshold early termination (0 = never early-terminates).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin new search (pulse); re-initialises the tracker.
- sad_valid  in  1  sad_bus/col/row valid this cycle.
- sad_bus  in  NUM_PART*SAD_W  packed SADs; partition p at [p*SAD_W +: SAD_W].
- search_col  in  COL_W  column of this position.
- search_row  in  ROW_W  row of this position.
- last_pos  in  1  qualifies sad_valid as the final position of the window.
- early_thr  in  SAD_W  early-termination threshold; sampled each cycle.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in SEARCH.
- result_valid  out  1  high in HOLD.
- early_term  out  1  in HOLD: 1 = ended by threshold, 0 = ended by last_pos.
- best_sad  out  NUM_PART*SAD_W  minimum SAD per partition.
- best_col  out  NUM_PART*COL_W  column of the minimum.
- best_row  out  NUM_PART*ROW_W  row of the minimum.
- pos_count  out  CNT_W  accepted positions in the current/last search.

Behaviour:
- Reset, asynchronous, all values take effect immediately:
  - state = IDLE; busy = 0; result_valid = 0; early_term = 0.
  - best_sad = all ones (SAD_MAX); best_col = 0; best_row = 0; pos_count = 0.
- States: IDLE, SEARCH, HOLD. All outputs are registered.
- IDLE:
  - start -> SEARCH next cycle; best_sad = SAD_MAX, col/row = 0, pos_count = 0, early_term = 0.
  - sad_valid is ignored.
- SEARCH, on sad_valid:
  - Per partition p: if sad_p < best_sad_p (strict unsigned), load sad_p, search_col, search_row.
  - Ties keep the earlier position (first in scan order wins).
  - pos_count increments and saturates at all ones.
- SEARCH exit conditions:
  - sad_valid and last_pos -> HOLD. result_valid rises the cycle after the final sample, and the results include that sample's update.
  - EARLY_EN = 1, sad_valid, and every post-update best_sad_p <= early_thr -> HOLD with early_term = 1. If last_pos is also set, early_term = 1 (threshold takes precedence).
  - start in SEARCH -> re-initialise as from IDLE and stay in SEARCH. A sad_valid in the same cycle is discarded.
- HOLD:
  - Outputs are frozen; result_valid = 1.
  - out_ready -> IDLE next cycle, unless start is also high, in which case go directly to SEARCH (re-initialised).
  - start without out_ready is ignored; the result must not be lost. sad_valid is ignored.
- Latency: 1 cycle from the accepting sad_valid edge to updated best_* or result_valid.
- No arithmetic overflow is possible: compare only, no accumulation.
- Reset mid-search or mid-HOLD aborts immediately to reset values; no result is emitted.

Decomposition:
- Shared package me_pkg holds:
  - state enum {IDLE, SEARCH, HOLD};
  - the SAD_MAX(SAD_W) constant function;
  - packed-slice helper functions for the sad/col/row buses.
- Sub-module sad_min_lane: one per partition (generate loop). It contains the compare/update register for a single partition and drives a le_thr flag. The top module holds the FSM, pos_count, and the AND-reduce of le_thr.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> best_sad = 0xFFFF per lane, result_valid = 0, busy = 0. sad_valid pulses in IDLE leave everything unchanged.
- Full window, NUM_PART=4:
  - Stimulus: start, then 8 positions with lane0 SADs {900,500,700,500,800,300,600,400} at col = 0..7, row = 2; last_pos on the 8th.
  - Expected: lane0 best = 300 at col 5 / row 2; the tie at 500 kept col 1; pos_count = 8; result_valid one cycle after the 8th sample; early_term = 0.
- Early termination:
  - Stimulus: early_thr = 50; all lanes see 40 at position 3.
  - Expected: HOLD after position 3, early_term = 1, pos_count = 3. Later sad_valid inputs are ignored.
- Handshake:
  - Hold out_ready = 0 for 5 cycles with start pulsed at cycle 2 -> result stays valid and unchanged.
  - out_ready = 1 -> IDLE next cycle.
  - Repeat with start and out_ready both high -> SEARCH directly, best_sad = 0xFFFF.
- Restart mid-search: start at position 4 of 8 -> pos_count = 0, minima cleared; the final result reflects only positions after the restart.
- Async reset during HOLD and during SEARCH: outputs go to reset values without waiting for a clock edge; the next start works normally.
